// File: rtl/div_share_arbiter.sv
// div_share_arbiter
//   Shares one external 8-bit signed divider between NUM_REQ requesters.
//   A round-robin arbiter picks one request in IDLE, latches its operands,
//   pulses div_start, waits for div_ready (or a timeout), then presents a
//   one-cycle response tagged with the requester index.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   req                   per-requester request level (held until its response)
//   req_dividend/divisor  packed 8-bit signed operands, requester i at [8i+7:8i]
//   gnt                   one-hot grant, held while a transaction is open
//   resp_valid            one-cycle response strobe
//   resp_id/quotient/remainder/err/dz
//                         response fields, held until the next response
//   div_start             one-cycle divider start pulse
//   div_dividend/divisor  latched operands presented to the divider
//   div_quotient/remainder/ready
//                         divider result and its one-cycle completion pulse
//   dbg_state             current FSM state for observation
//
// Handshake: req is a level that the requester holds until it sees
// resp_valid with its own resp_id; resp_valid is a strobe with no back
// pressure. div_start and div_ready are single-cycle pulses; div_ready is
// only honoured in WAIT, so a stale pulse in any other state is dropped.
module div_share_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_dividend,
    input  logic [8*NUM_REQ-1:0]   req_divisor,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   resp_valid,
    output logic [1:0]             resp_id,
    output logic [7:0]             resp_quotient,
    output logic [7:0]             resp_remainder,
    output logic                   resp_err,
    output logic                   resp_dz,
    output logic                   div_start,
    output logic [7:0]             div_dividend,
    output logic [7:0]             div_divisor,
    input  logic [7:0]             div_quotient,
    input  logic [7:0]             div_remainder,
    input  logic                   div_ready,
    output logic [1:0]             dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [1:0]         ptr;
    logic [1:0]         id_q;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         winner;
    logic [1:0]         cand;
    logic               found;
    logic               timeout_hit;

    assign dbg_state   = state;
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Round-robin search: first asserted req at or above ptr, wrapping mod 4.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ptr + 2'(i);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        div_start  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE:  if (found) state_next = ISSUE;
            ISSUE: begin
                div_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT:  if (div_ready || timeout_hit) state_next = RESP;
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr            <= '0;
            id_q           <= '0;
            cnt            <= '0;
            gnt            <= '0;
            div_dividend   <= '0;
            div_divisor    <= '0;
            resp_id        <= '0;
            resp_quotient  <= '0;
            resp_remainder <= '0;
            resp_err       <= 1'b0;
            resp_dz        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (found) begin
                        id_q         <= winner;
                        ptr          <= winner + 2'd1;
                        gnt          <= NUM_REQ'(1) << winner;
                        div_dividend <= req_dividend[{winner, 3'b000} +: 8];
                        div_divisor  <= req_divisor[{winner, 3'b000} +: 8];
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // div_ready is tested first so it wins a tie with the timeout.
                    if (div_ready) begin
                        resp_quotient  <= div_quotient;
                        resp_remainder <= div_remainder;
                        resp_err       <= 1'b0;
                        resp_id        <= id_q;
                        resp_dz        <= (div_divisor == 8'h00);
                    end else if (timeout_hit) begin
                        resp_quotient  <= '0;
                        resp_remainder <= '0;
                        resp_err       <= 1'b1;
                        resp_id        <= id_q;
                        resp_dz        <= (div_divisor == 8'h00);
                    end
                end
                RESP: begin
                    gnt          <= '0;
                    div_dividend <= '0;
                    div_divisor  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_arbiter.sv
module tb_div_share_arbiter;

  localparam int TIMEOUT = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_dividend = '0;
  logic [31:0] req_divisor = '0;
  logic [3:0]  gnt;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [7:0]  resp_quotient;
  logic [7:0]  resp_remainder;
  logic        resp_err;
  logic        resp_dz;
  logic        div_start;
  logic [7:0]  div_dividend;
  logic [7:0]  div_divisor;
  logic [7:0]  div_quotient = '0;
  logic [7:0]  div_remainder = '0;
  logic        div_ready = 1'b0;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // expected response: {id[1:0], quotient[7:0], remainder[7:0], err, dz}
  logic [19:0] exp_q[$];

  div_share_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .req(req),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .gnt(gnt), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_quotient(resp_quotient), .resp_remainder(resp_remainder),
    .resp_err(resp_err), .resp_dz(resp_dz),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_ready(div_ready), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- divider behaviour ----------------
  // Signed truncating quotient, magnitude remainder; divide-by-zero returns
  // quotient FF and the dividend as remainder.
  function automatic logic [15:0] div_fn(input logic [7:0] a, input logic [7:0] b);
    int sa, sb, q, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) return {8'hFF, a};
    q = sa / sb;
    r = (sa < 0 ? -sa : sa) % (sb < 0 ? -sb : sb);
    return {q[7:0], r[7:0]};
  endfunction

  int          div_lat = 3;
  bit          div_en  = 1'b1;
  int          div_cnt = 0;
  logic [7:0]  div_a = '0;
  logic [7:0]  div_b = '0;

  // Divider model: div_ready appears div_lat cycles after the div_start cycle.
  always @(negedge clock) begin
    div_ready = 1'b0;
    if (div_cnt > 0) begin
      div_cnt--;
      if (div_cnt == 0) begin
        div_ready = 1'b1;
        {div_quotient, div_remainder} = div_fn(div_a, div_b);
      end
    end
    if (div_start && div_en) begin
      div_a   = div_dividend;
      div_b   = div_divisor;
      div_cnt = div_lat;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic prev_start = 1'b0;

  always @(negedge clock) begin
    logic [19:0] e;
    if (!reset) begin
      checks++;
      if (!$onehot0(gnt)) begin
        errors++;
        $display("FAIL gnt_onehot got=%b required at most one bit", gnt);
      end
      checks++;
      if (div_start && prev_start) begin
        errors++;
        $display("FAIL div_start_pulse got two consecutive cycles required one");
      end
      prev_start = div_start;
      if (resp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp got id=%0d q=%02h r=%02h err=%0b required no response",
                   resp_id, resp_quotient, resp_remainder, resp_err);
        end else begin
          e = exp_q.pop_front();
          if ({resp_id, resp_quotient, resp_remainder, resp_err, resp_dz} !== e ||
              gnt !== (4'b0001 << e[19:18])) begin
            errors++;
            $display("FAIL resp got id=%0d q=%02h r=%02h err=%0b dz=%0b gnt=%b required id=%0d q=%02h r=%02h err=%0b dz=%0b",
                     resp_id, resp_quotient, resp_remainder, resp_err, resp_dz, gnt,
                     e[19:18], e[17:10], e[9:2], e[1], e[0]);
          end
        end
      end
    end else begin
      prev_start = 1'b0;
    end
  end

  // ---------------- reference model + driver ----------------
  int mptr = 0;

  task automatic check_eq(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  // Issue requests for every bit of mask (held until served); the expected
  // serving order is the upward cyclic order from the model pointer.
  task automatic run_scenario(input logic [3:0] mask, input logic [31:0] dvd,
                              input logic [31:0] dvs, input bit drop_early,
                              input bit scramble, output int st_cyc, output int vl_cyc,
                              output logic [7:0] fq, output logic [7:0] fr,
                              output logic ferr, output logic fdz);
    int idx, last;
    bit err, done;
    logic [15:0] qr;
    err = !div_en || (div_lat > TIMEOUT);
    last = -1;
    done = 1'b0;
    st_cyc = -1;
    vl_cyc = -1;
    fq = '0; fr = '0; ferr = 1'b0; fdz = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = (mptr + k) % 4;
      if (mask[idx]) begin
        qr = err ? 16'h0000 : div_fn(dvd[8*idx +: 8], dvs[8*idx +: 8]);
        exp_q.push_back({2'(idx), qr, err, (dvs[8*idx +: 8] == 8'h00)});
        last = idx;
      end
    end
    if (last >= 0) mptr = (last + 1) % 4;
    req_dividend = dvd;
    req_divisor  = dvs;
    req          = mask;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clock);
      if (div_start && st_cyc < 0) st_cyc = c;
      if (resp_valid) begin
        if (vl_cyc < 0) begin
          vl_cyc = c;
          fq = resp_quotient; fr = resp_remainder; ferr = resp_err; fdz = resp_dz;
        end
        req[resp_id] = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) begin
          if (drop_early) req[i] = 1'b0;
          if (scramble) begin
            req_dividend[8*i +: 8] = 8'($urandom);
            req_divisor[8*i +: 8]  = 8'($urandom);
          end
        end
      end
      if (req == 4'b0000 && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL scenario_timeout got pending=%0d req=%b required all served", exp_q.size(), req);
      req = '0;
      exp_q.delete();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int st, vl, seen;
    logic [7:0] fq, fr;
    logic fe, fd;
    logic [3:0] m;

    // reset
    reset = 1'b1;
    @(negedge clock);
    check_eq("reset_outputs",
             int'({gnt, resp_valid, resp_id, resp_quotient, resp_remainder, resp_err,
                   resp_dz, div_start}) | int'({div_dividend, div_divisor}), 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // all four held: served 0,1,2,3 with own operands
    run_scenario(4'b1111, 32'h40_E7_11_64, 32'h05_FD_03_0A, 1'b0, 1'b1, st, vl, fq, fr, fe, fd);

    // single request, latency 3: start at cycle 1, response at cycle 5
    run_scenario(4'b0001, 32'h0000_009C, 32'h0000_0007, 1'b0, 1'b0, st, vl, fq, fr, fe, fd);
    check_eq("basic_start_cycle", st, 1);
    check_eq("basic_valid_cycle", vl, 5);
    check_eq("basic_quotient", int'(fq), 'hF2);
    check_eq("basic_remainder", int'(fr), 2);
    check_eq("basic_err", int'(fe), 0);

    // serve 1, then 0 and 2 together: 2 must precede 0
    run_scenario(4'b0010, 32'h0000_2D00, 32'h0000_0400, 1'b0, 1'b0, st, vl, fq, fr, fe, fd);
    run_scenario(4'b0101, 32'h0050_0019, 32'h0009_0002, 1'b0, 1'b0, st, vl, fq, fr, fe, fd);

    // divider never answers: timeout after 8 WAIT cycles
    div_en = 1'b0;
    run_scenario(4'b1000, 32'h3C00_0000, 32'h0600_0000, 1'b0, 1'b0, st, vl, fq, fr, fe, fd);
    check_eq("timeout_valid_cycle", vl, 2 + TIMEOUT);
    check_eq("timeout_err", int'(fe), 1);
    check_eq("timeout_qr", int'({fq, fr}), 0);
    div_en = 1'b1;
    run_scenario(4'b1000, 32'h3C00_0000, 32'h0600_0000, 1'b0, 1'b0, st, vl, fq, fr, fe, fd);
    check_eq("after_timeout_err", int'(fe), 0);

    // divide by zero passes divider outputs through with dz set
    run_scenario(4'b0100, 32'h0019_0000, 32'h0000_0000, 1'b0, 1'b0, st, vl, fq, fr, fe, fd);
    check_eq("dz_flag", int'(fd), 1);
    check_eq("dz_err", int'(fe), 0);
    check_eq("dz_passthrough", int'({fq, fr}), int'({8'hFF, 8'd25}));

    // ready coinciding with timeout wins; one cycle later is a timeout
    div_lat = TIMEOUT;
    run_scenario(4'b0011, 32'h0000_7F81, 32'h0000_0A03, 1'b0, 1'b0, st, vl, fq, fr, fe, fd);
    div_lat = TIMEOUT + 1;
    run_scenario(4'b0010, 32'h0000_2200, 32'h0000_0500, 1'b0, 1'b0, st, vl, fq, fr, fe, fd);

    // requester drops req right after its grant: response still issues
    div_lat = 3;
    run_scenario(4'b0001, 32'h0000_00CE, 32'h0000_0004, 1'b1, 1'b1, st, vl, fq, fr, fe, fd);
    check_eq("drop_early_served", (vl > 0) ? 1 : 0, 1);

    // randomized traffic
    for (int n = 0; n < 24; n++) begin
      logic [31:0] a, b;
      m = 4'($urandom_range(1, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b[8*$urandom_range(0, 3) +: 8] = 8'h00;
      div_lat = $urandom_range(1, TIMEOUT + 1);
      run_scenario(m, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   st, vl, fq, fr, fe, fd);
    end

    // reset during WAIT: transaction discarded, late ready ignored, ptr back to 0
    div_lat = 6;
    req_dividend = 32'h0014_0000;
    req_divisor  = 32'h0003_0000;
    req = 4'b0100;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    check_eq("midreset_outputs",
             int'({gnt, resp_valid, resp_id, resp_quotient, resp_remainder, resp_err,
                   resp_dz, div_start}) | int'({div_dividend, div_divisor}), 0);
    @(negedge clock);
    reset = 1'b0;
    req = 4'b0000;
    mptr = 0;
    seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (resp_valid) seen++;
    end
    check_eq("midreset_no_resp", seen, 0);
    div_lat = 3;
    run_scenario(4'b1010, 32'h6400_E200, 32'h0900_0500, 1'b0, 1'b0, st, vl, fq, fr, fe, fd);

    repeat (3) @(negedge clock);
    check_eq("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish required finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
